trigger_delay: RTL and testbench
================================

# trigger_delay

Arming and trigger-delay stage sitting directly upstream of `pulser` inside `glitch_control`. It takes the target's asynchronous `trigger_i`, synchronises it and edge-detects it. Once armed by `uart_handler`, it waits the programmed `delay` clock cycles after the selected trigger edge, then issues the one-cycle enable strobe that starts the pulse train. This stage closes the gap where `trigger_i` and `pulse_delay` were previously unused.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flops in the `trigger_i` synchroniser; must be ≥2.
- `DELAY_WIDTH`, 16: width of the delay counter and `delay_i`.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `arm_i`  in  1  one-cycle arm strobe from `uart_handler`
- `disarm_i`  in  1  one-cycle abort strobe
- `edge_sel_i`  in  1  0 = rising edge, 1 = falling edge; latched at arm
- `delay_i`  in  DELAY_WIDTH  trigger-to-fire delay in cycles; latched at arm
- `trigger_i`  in  1  asynchronous trigger from target
- `pulser_ready_i`  in  1  `ready_o` from `pulser`
- `fire_o`  out  1  one-cycle strobe to `pulser` `en`
- `armed_o`  out  1  high while waiting for the trigger edge
- `busy_o`  out  1  high while in DELAY or WAIT_DONE
- `missed_o`  out  1  sticky: delay expired while the pulser was not ready

## Operation
- States: IDLE, ARMED, DELAY, WAIT_DONE.
- IDLE: on `arm_i`, latch `delay_i` into `dly_q` and `edge_sel_i` into `edge_q`, clear `missed_o`, then go to ARMED. In any other state, `arm_i` is ignored.
- ARMED, on a detected selected edge:
  - if `dly_q == 0`: go to WAIT_DONE and fire (see fire rule).
  - else: go to DELAY and load `cnt = dly_q - 1`.
- DELAY:
  - if `cnt == 0`: go to WAIT_DONE and fire.
  - else: `cnt <= cnt - 1`.
- Fire rule:
  - if `pulser_ready_i` is high in the deciding cycle, `fire_o` = 1 for the next cycle.
  - otherwise no fire: set `missed_o` and go to IDLE instead of WAIT_DONE.
- WAIT_DONE: set `seen_busy` when `pulser_ready_i` is low. Go to IDLE on the first cycle with `pulser_ready_i` high and `seen_busy` set.
- One-shot behaviour: every fire needs a new arm.
- `disarm_i` in ARMED or DELAY: go to IDLE next cycle and clear `cnt`. In IDLE and WAIT_DONE it has no effect. If `arm_i` and `disarm_i` arrive in the same cycle in IDLE, disarm wins (stay in IDLE).
- Edge detect compares the last synchroniser stage with a registered copy of it.
  - For the first SYNC_STAGES+1 cycles after reset, edges are masked (warm-up counter), so a trigger already high at reset does not produce a false rising edge.
  - Edges seen outside ARMED are discarded, not queued.
- Delay arithmetic is unsigned and has no wrap. Maximum delay is 2^DELAY_WIDTH−1.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt`/`dly_q`/`edge_q`/`seen_busy` = 0, synchroniser and edge registers = 0.
- `armed_o` is high the cycle after `arm_i` is sampled.
- Edge detection: a `trigger_i` transition sampled at clock edge E0 is detected in cycle E0+SYNC_STAGES.
- Fire latency: `fire_o` is high exactly D+1 cycles after the detection cycle, where D = latched delay. Total pin-to-fire latency is SYNC_STAGES+1+D cycles; with defaults, D=0 gives 3.
- `fire_o` is never high for more than 1 consecutive cycle.
- `busy_o` = (state ∈ {DELAY, WAIT_DONE}); `armed_o` = (state == ARMED). Both are registered.
- `rst` asserted mid-operation: next cycle is IDLE with all outputs 0, including a `fire_o` that would otherwise have been due.

## Structure
- Shared package `glitch_pkg`: state enum `trig_state_t`, `DELAY_WIDTH` default constant, edge-select encodings `EDGE_RISE`/`EDGE_FALL`.
- One sub-module: `sync_edge_detect` (parameter SYNC_STAGES; outputs `rise_o`, `fall_o`, warm-up masking inside).
- Integration in `glitch_control`:
  - `fire_o` drives pulser `en`.
  - `pulser_ready` feeds `pulser_ready_i`.
  - `pulse_delay` feeds `delay_i`.
  - `pulse_en` from `uart_handler` becomes `arm_i`.

## Test plan
- Arm with D=10, rising edge; raise `trigger_i` 20 cycles later -> `fire_o` one cycle high at exactly 2+1+10=13 cycles after the sampling edge; `armed_o` falls with detection.
- D=0, falling edge selected; rising then falling trigger -> rising is ignored; `fire_o` 3 cycles after the falling sample.
- D=1000, `disarm_i` at cycle 500 of DELAY -> IDLE, no `fire_o`, `busy_o` 0 the next cycle; a later trigger produces nothing until re-armed.
- Hold `pulser_ready_i` low through D=5 expiry -> no `fire_o`, `missed_o`=1 and stays set; the next `arm_i` clears it.
- `trigger_i` high through reset, arm at cycle 1 -> no fire (warm-up mask); a second arm in ARMED has no effect, and the same-cycle arm+disarm test stays in IDLE.
- Fire, then model pulser ready low for 40 cycles -> stay in WAIT_DONE with `busy_o`=1; IDLE the cycle after ready returns; `rst` during DELAY gives all outputs 0 the next cycle.

Source files
------------

// File: rtl/glitch_pkg.sv
// -----------------------------------------------------------------------------
// glitch_pkg
//
// Shared definitions for the glitch_control datapath. This slice uses them in
// trigger_delay and sync_edge_detect.
//
// Contents:
//   DELAY_WIDTH_DEFAULT  default width of the trigger-to-fire delay counter
//   SYNC_STAGES_DEFAULT  default depth of the trigger synchroniser
//   EDGE_RISE/EDGE_FALL  encodings of the edge_sel_i input
//   trig_state_t         state encoding of the trigger_delay controller
//   is_busy_state()      true for the states that report busy_o
// -----------------------------------------------------------------------------
package glitch_pkg;

  localparam int DELAY_WIDTH_DEFAULT = 16;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // edge_sel_i encodings, latched at arm time.
  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,  // waiting for an arm strobe
    ST_ARMED     = 2'd1,  // waiting for the selected trigger edge
    ST_DELAY     = 2'd2,  // counting down the programmed delay
    ST_WAIT_DONE = 2'd3   // fired; waiting for the pulser to finish
  } trig_state_t;

  // DELAY and WAIT_DONE are the states in which a pulse is in flight.
  function automatic logic is_busy_state(input trig_state_t s);
    return (s == ST_DELAY) || (s == ST_WAIT_DONE);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
//
// Brings the asynchronous target trigger into the clk domain and produces
// registered one-cycle rise/fall pulses.
//
// A transition sampled by the first synchroniser flop at clock edge E0 shows
// up on rise_o/fall_o in the cycle following edge E0+SYNC_STAGES. For the
// first SYNC_STAGES+1 edges after reset the pulses are masked, so a trigger
// that is already high when reset is released is not mistaken for a rising
// edge.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth, must be >= 2
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   trigger_i  in   asynchronous trigger from the target
//   rise_o     out  one-cycle pulse: synchronised trigger went 0 -> 1
//   fall_o     out  one-cycle pulse: synchronised trigger went 1 -> 0
// -----------------------------------------------------------------------------
module sync_edge_detect
  import glitch_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger_i,
  output logic rise_o,
  output logic fall_o
);

  // Edges are masked until the warm-up counter reaches this value.
  localparam int WARMUP  = SYNC_STAGES + 1;
  localparam int WARM_W  = $clog2(WARMUP + 1);

  logic [SYNC_STAGES-1:0] sync_q;    // sync_q[0] faces the pin
  logic                   last_q;    // delayed copy of the final stage
  logic [WARM_W-1:0]      warm_cnt;
  logic                   warm_done;
  logic                   sync_out;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_cnt == WARM_W'(WARMUP));

  // NOTE: non-blocking assignments make every flop capture its neighbour's
  // pre-edge value; blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      last_q   <= 1'b0;
      warm_cnt <= '0;
      rise_o   <= 1'b0;
      fall_o   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trigger_i};
      last_q <= sync_out;

      if (!warm_done) begin
        warm_cnt <= warm_cnt + WARM_W'(1);
      end

      // Registered pulses; compare against the previous sample of the
      // synchroniser output so each transition yields exactly one pulse.
      rise_o <= warm_done &&  sync_out && !last_q;
      fall_o <= warm_done && !sync_out &&  last_q;
    end
  end

endmodule

// File: rtl/trigger_delay.sv
// -----------------------------------------------------------------------------
// trigger_delay
//
// Arming and trigger-delay stage in front of the pulser. Once armed, it waits
// for the selected edge of the synchronised target trigger, counts the
// programmed number of cycles, then issues a one-cycle fire strobe that starts
// the pulse train. Each fire consumes the arm; a new arm is needed for the
// next one.
//
// Latency: with D the delay latched at arm time, fire_o rises
// SYNC_STAGES + 1 + D cycles after the trigger transition is first sampled.
//
// If the delay expires while the pulser is not ready, nothing is fired, the
// sticky missed_o flag is raised and the controller returns to idle. missed_o
// is cleared by the next accepted arm.
//
// Parameters:
//   SYNC_STAGES  trigger synchroniser depth (>= 2)
//   DELAY_WIDTH  width of delay_i and the delay counter
//
// Ports:
//   clk             in   system clock
//   rst             in   synchronous, active-high reset
//   arm_i           in   one-cycle arm strobe (accepted only in idle)
//   disarm_i        in   one-cycle abort strobe (acts in armed/delay)
//   edge_sel_i      in   0 = rising, 1 = falling; latched at arm
//   delay_i         in   trigger-to-fire delay in cycles; latched at arm
//   trigger_i       in   asynchronous trigger from the target
//   pulser_ready_i  in   pulser idle/ready indication
//   fire_o          out  one-cycle enable strobe to the pulser
//   armed_o         out  waiting for the trigger edge
//   busy_o          out  counting the delay or waiting for the pulser
//   missed_o        out  sticky: delay expired while the pulser was busy
// -----------------------------------------------------------------------------
module trigger_delay
  import glitch_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int DELAY_WIDTH = DELAY_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm_i,
  input  logic                   disarm_i,
  input  logic                   edge_sel_i,
  input  logic [DELAY_WIDTH-1:0] delay_i,
  input  logic                   trigger_i,
  input  logic                   pulser_ready_i,
  output logic                   fire_o,
  output logic                   armed_o,
  output logic                   busy_o,
  output logic                   missed_o
);

  trig_state_t            state_q, state_d;
  logic [DELAY_WIDTH-1:0] dly_q, dly_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic                   edge_q, edge_d;
  logic                   seen_busy_q, seen_busy_d;

  logic fire_d, armed_d, busy_d, missed_d;

  logic rise, fall;
  logic trig_edge;   // selected edge, valid only while armed
  logic arm_accept;  // arm strobe taken this cycle
  logic expire;      // the delay runs out this cycle: fire or miss

  // ---------------------------------------------------------------------------
  // Trigger synchroniser and edge detector
  // ---------------------------------------------------------------------------
  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk       (clk),
    .rst       (rst),
    .trigger_i (trigger_i),
    .rise_o    (rise),
    .fall_o    (fall)
  );

  assign trig_edge  = (edge_q == EDGE_RISE) ? rise : fall;

  // Disarm beats a simultaneous arm.
  assign arm_accept = (state_q == ST_IDLE) && arm_i && !disarm_i;

  // The deciding cycle: a zero delay decides on the edge itself, otherwise
  // on the cycle the counter has reached zero. Disarm always takes priority.
  always_comb begin
    expire = 1'b0;
    case (state_q)
      ST_ARMED: expire = !disarm_i && trig_edge && (dly_q == '0);
      ST_DELAY: expire = !disarm_i && (cnt_q == '0);
      default:  expire = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register (also holds the registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dly_q       <= '0;
      cnt_q       <= '0;
      edge_q      <= 1'b0;
      seen_busy_q <= 1'b0;
      fire_o      <= 1'b0;
      armed_o     <= 1'b0;
      busy_o      <= 1'b0;
      missed_o    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      seen_busy_q <= seen_busy_d;
      fire_o      <= fire_d;
      armed_o     <= armed_d;
      busy_o      <= busy_d;
      missed_o    <= missed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    seen_busy_d = seen_busy_q;

    case (state_q)
      ST_IDLE: begin
        if (arm_accept) begin
          dly_d   = delay_i;
          edge_d  = edge_sel_i;
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (disarm_i) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (trig_edge) begin
          if (dly_q == '0) begin
            state_d = pulser_ready_i ? ST_WAIT_DONE : ST_IDLE;
          end else begin
            // One cycle of the delay is spent entering DELAY.
            cnt_d   = dly_q - DELAY_WIDTH'(1);
            state_d = ST_DELAY;
          end
        end
      end

      ST_DELAY: begin
        if (disarm_i) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = pulser_ready_i ? ST_WAIT_DONE : ST_IDLE;
        end else begin
          cnt_d = cnt_q - DELAY_WIDTH'(1);
        end
      end

      ST_WAIT_DONE: begin
        // The pulser must be seen busy before its ready counts as "done";
        // the ready that allowed the fire is still high on entry.
        if (!pulser_ready_i) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          seen_busy_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (expire) begin
      seen_busy_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (values registered alongside the state)
  // ---------------------------------------------------------------------------
  always_comb begin
    fire_d   = expire && pulser_ready_i;
    armed_d  = (state_d == ST_ARMED);
    busy_d   = is_busy_state(state_d);
    missed_d = missed_o;
    if (expire && !pulser_ready_i) begin
      missed_d = 1'b1;
    end else if (arm_accept) begin
      missed_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_trigger_delay.sv
// -----------------------------------------------------------------------------
// tb_trigger_delay
//
// Self-checking bench for trigger_delay (default parameters).
//   1. A table of per-cycle input/expected-output records.
//   2. Hand-written multi-cycle scenarios with explicit latencies.
//   3. Random stimulus compared against an event-time reference model.
// -----------------------------------------------------------------------------
module tb_trigger_delay;
  import glitch_pkg::*;

  localparam int SYNC = 2;
  localparam int DW   = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm_i;
  logic          disarm_i;
  logic          edge_sel_i;
  logic [DW-1:0] delay_i;
  logic          trigger_i;
  logic          pulser_ready_i;
  logic          fire_o;
  logic          armed_o;
  logic          busy_o;
  logic          missed_o;
  logic [3:0]    outs;

  assign outs = {fire_o, armed_o, busy_o, missed_o};

  always #5 clk = ~clk;

  trigger_delay #(
    .SYNC_STAGES (SYNC),
    .DELAY_WIDTH (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .arm_i          (arm_i),
    .disarm_i       (disarm_i),
    .edge_sel_i     (edge_sel_i),
    .delay_i        (delay_i),
    .trigger_i      (trigger_i),
    .pulser_ready_i (pulser_ready_i),
    .fire_o         (fire_o),
    .armed_o        (armed_o),
    .busy_o         (busy_o),
    .missed_o       (missed_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Simple pulser stand-in: after each fire, ready drops for busy_len cycles.
  bit auto_pulser = 1'b0;
  int busy_len    = 3;
  int pulser_left = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_pulser) begin
      if (fire_o) pulser_left = busy_len;
      else if (pulser_left > 0) pulser_left--;
      pulser_ready_i = (pulser_left == 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; arm_i = 1'b0; disarm_i = 1'b0;
    tick();
    rst = 1'b0;
    pulser_left = 0;
    pulser_ready_i = 1'b1;
  endtask

  task automatic arm(input int d, input logic sel);
    delay_i = DW'(d); edge_sel_i = sel; arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask

  task automatic run(input int n, output int first, output int nfire);
    first = -1; nfire = 0;
    for (int c = 1; c <= n; c++) begin
      tick();
      if (fire_o) begin
        nfire++;
        if (first < 0) first = c;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Time is counted in clock edges since the last reset edge.
  // A trigger level first sampled at edge n is acted on at edge n+SYNC+1 (if
  // that edge is at least SYNC+3, i.e. past warm-up). A delay D acted on at
  // edge k decides at edge k+D.
  // ---------------------------------------------------------------------------
  bit         m_armed, m_wait, m_seen, m_missed, m_sel;
  int         m_d, m_fire_at, m_since;
  logic [7:0] m_hist;   // m_hist[i] = trigger sampled i edges ago

  task automatic rstep(input int idx);
    bit         fire_now;
    bit         sel_seen;
    bit         decide;
    logic [3:0] exp_v;
    fire_now = 1'b0;
    decide   = 1'b0;
    if (rst) begin
      m_armed = 0; m_wait = 0; m_seen = 0; m_missed = 0; m_sel = 0;
      m_d = 0; m_fire_at = -1; m_since = 0; m_hist = '0;
    end else begin
      m_hist  = {m_hist[6:0], trigger_i};
      m_since = m_since + 1;
      sel_seen = (m_since >= SYNC + 3) &&
                 (m_sel ? ( m_hist[SYNC+2] && !m_hist[SYNC+1])
                        : (!m_hist[SYNC+2] &&  m_hist[SYNC+1]));
      if (m_wait) begin
        if (!pulser_ready_i) m_seen = 1;
        else if (m_seen) begin m_wait = 0; m_seen = 0; end
      end else if (m_fire_at >= 0) begin
        if (disarm_i) m_fire_at = -1;
        else if (m_since == m_fire_at) decide = 1;
      end else if (m_armed) begin
        if (disarm_i) m_armed = 0;
        else if (sel_seen) begin
          m_armed = 0;
          if (m_d == 0) decide = 1;
          else m_fire_at = m_since + m_d;
        end
      end else if (arm_i && !disarm_i) begin
        m_armed = 1; m_d = int'(delay_i); m_sel = edge_sel_i; m_missed = 0;
      end
      if (decide) begin
        m_fire_at = -1;
        if (pulser_ready_i) begin m_wait = 1; m_seen = 0; fire_now = 1; end
        else m_missed = 1;
      end
    end
    exp_v = {fire_now, m_armed, (m_fire_at >= 0) || m_wait, m_missed};
    tick();
    check($sformatf("rand_c%0d", idx), outs, exp_v);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic          rst, arm, dis, sel, rdy, trg;
    logic [DW-1:0] dly;
    logic [3:0]    exp;   // {fire, armed, busy, missed}
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  int f, n, first_low;
  logic a2, a3, b4;

  initial begin
    rst = 1'b1; arm_i = 1'b0; disarm_i = 1'b0; edge_sel_i = 1'b0;
    delay_i = '0; trigger_i = 1'b0; pulser_ready_i = 1'b1;

    //                rst arm dis sel rdy trg dly      exp
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,16'd0,4'b0000}; // reset
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'd0,4'b0000};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,16'd0,4'b0100}; // arm D=0 rise
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,16'd0,4'b0100}; // trigger sampled
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,16'd0,4'b0100};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,16'd0,4'b0100};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,16'd0,4'b1010}; // fire, 3 later
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0,4'b0010}; // pulser busy
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,16'd0,4'b0000}; // pulser done
    vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,16'd0,4'b0000}; // arm+disarm
    vecs[10] = '{1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,16'd1,4'b0100}; // arm D=1 fall
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'd0,4'b0100}; // falling sampled
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'd0,4'b0100};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'd0,4'b0100};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'd0,4'b0010}; // delay
    vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,4'b0001}; // missed
    vecs[16] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,16'd0,4'b0001}; // sticky
    vecs[17] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,16'd0,4'b0100}; // arm clears
    vecs[18] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,16'd0,4'b0000}; // disarm

    for (int i = 0; i < NVEC; i++) begin
      rst = vecs[i].rst; arm_i = vecs[i].arm; disarm_i = vecs[i].dis;
      edge_sel_i = vecs[i].sel; pulser_ready_i = vecs[i].rdy;
      trigger_i = vecs[i].trg; delay_i = vecs[i].dly;
      tick();
      check($sformatf("vec%0d", i), outs, vecs[i].exp);
    end

    // --- A: D=10 rising, trigger 20 cycles after arm ----------------------
    auto_pulser = 1'b1; busy_len = 3; trigger_i = 1'b0;
    do_reset();
    check("reset_outs", outs, 4'b0000);
    repeat (4) tick();
    arm(10, EDGE_RISE);
    check("A_armed_after_arm", armed_o, 1'b1);
    repeat (20) tick();
    trigger_i = 1'b1;
    tick();                                   // sampling edge E0
    f = -1; n = 0; a2 = 1'b0; a3 = 1'b1; b4 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (fire_o) begin n++; if (f < 0) f = c; end
      if (c == 2) a2 = armed_o;
      if (c == 3) a3 = armed_o;
      if (c == 4) b4 = busy_o;
    end
    check("A_fire_latency", f, 13);
    check("A_fire_once", n, 1);
    check("A_armed_before_detect", a2, 1'b1);
    check("A_armed_falls", a3, 1'b0);
    check("A_busy_in_delay", b4, 1'b1);

    // --- B: D=0 falling; rising edge ignored ------------------------------
    trigger_i = 1'b0;
    repeat (5) tick();
    arm(0, EDGE_FALL);
    trigger_i = 1'b1;
    run(8, f, n);
    check("B_rise_ignored", n, 0);
    check("B_still_armed", armed_o, 1'b1);
    trigger_i = 1'b0;
    tick();
    run(10, f, n);
    check("B_fall_latency", f, 3);
    check("B_fire_once", n, 1);

    // --- C: D=1000, disarm mid-delay --------------------------------------
    arm(1000, EDGE_RISE);
    trigger_i = 1'b1;
    tick();
    repeat (3) tick();
    check("C_in_delay", outs, 4'b0010);
    run(499, f, n);
    check("C_no_early_fire", n, 0);
    disarm_i = 1'b1;
    tick();
    disarm_i = 1'b0;
    check("C_disarmed", outs, 4'b0000);
    trigger_i = 1'b0;
    repeat (4) tick();
    trigger_i = 1'b1;
    run(20, f, n);
    check("C_no_fire_unarmed", n, 0);
    check("C_idle", outs, 4'b0000);

    // --- D: pulser not ready at expiry ------------------------------------
    auto_pulser = 1'b0; pulser_ready_i = 1'b0;
    trigger_i = 1'b0;
    repeat (4) tick();
    arm(5, EDGE_RISE);
    trigger_i = 1'b1;
    tick();
    run(15, f, n);
    check("D_no_fire", n, 0);
    check("D_missed", outs, 4'b0001);
    repeat (10) tick();
    check("D_missed_sticky", outs, 4'b0001);
    arm(3, EDGE_RISE);
    check("D_arm_clears_missed", outs, 4'b0100);
    disarm_i = 1'b1;
    tick();
    disarm_i = 1'b0;
    check("D_disarm", outs, 4'b0000);

    // --- E: trigger high through reset, second arm, arm+disarm ------------
    auto_pulser = 1'b1; busy_len = 3;
    trigger_i = 1'b1;
    do_reset();
    arm(2, EDGE_RISE);
    run(10, f, n);
    check("E_warmup_no_fire", n, 0);
    check("E_still_armed", armed_o, 1'b1);
    arm(50, EDGE_FALL);
    check("E_rearm_ignored", outs, 4'b0100);
    trigger_i = 1'b0;
    run(8, f, n);
    check("E_fall_ignored", n, 0);
    trigger_i = 1'b1;
    tick();
    run(10, f, n);
    check("E_first_arm_latency", f, 5);
    arm_i = 1'b1; disarm_i = 1'b1; delay_i = '0;
    tick();
    arm_i = 1'b0; disarm_i = 1'b0;
    check("E_arm_disarm_idle", outs, 4'b0000);

    // --- F: long pulser busy, then reset during delay ---------------------
    busy_len = 40;
    trigger_i = 1'b0;
    repeat (4) tick();
    arm(0, EDGE_RISE);
    trigger_i = 1'b1;
    tick();
    run(3, f, n);
    check("F_fire", f, 3);
    first_low = -1;
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (!busy_o && first_low < 0) first_low = c;
    end
    check("F_wait_done_release", first_low, 41);
    busy_len = 3;
    trigger_i = 1'b0;
    repeat (4) tick();
    arm(3, EDGE_RISE);
    trigger_i = 1'b1;
    tick();
    repeat (5) tick();
    check("F_delay_before_rst", outs, 4'b0010);
    rst = 1'b1;
    tick();
    check("F_rst_kills_fire", outs, 4'b0000);
    rst = 1'b0;
    tick();
    check("F_after_rst", outs, 4'b0000);

    // --- Random against the reference model -------------------------------
    auto_pulser = 1'b0;
    rst = 1'b1; arm_i = 1'b0; disarm_i = 1'b0; pulser_ready_i = 1'b1;
    rstep(-1);
    for (int i = 0; i < 4000; i++) begin
      rst            = ($urandom_range(0, 399) == 0);
      arm_i          = ($urandom_range(0, 11) == 0);
      disarm_i       = ($urandom_range(0, 59) == 0);
      edge_sel_i     = 1'($urandom_range(0, 1));
      delay_i        = DW'($urandom_range(0, 6));
      pulser_ready_i = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 5) == 0) trigger_i = ~trigger_i;
      rstep(i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
